// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl: PmodJSTK transfer sequencer and field unpacker; JSTK_WATCHDOG_EN adds a per-transfer timeout.
module jstk_poll_ctrl #(
  parameter int POLL_PERIOD    = 2_500_000,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        poll_now,
  input  logic [1:0]  leds,
  output logic        spi_trigger,
  output logic [39:0] spi_out_bytes,
  input  logic [39:0] spi_in_bytes,
  input  logic        spi_cs,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  buttons,
  output logic        valid,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, LATCH} state_t;
  localparam int PW = $clog2(POLL_PERIOD);
  state_t        state;
  logic [PW-1:0] cnt;
  logic          cs_q, tick, launch, timeout;
  logic          unused_in;
  assign unused_in = ^{spi_in_bytes[31:26], spi_in_bytes[15:10], spi_in_bytes[7:3]};
  assign tick   = cnt == PW'(POLL_PERIOD - 1);
  assign launch = enable & (tick | poll_now) & (state == IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      cs_q <= 1'b1;
    end else begin
      cnt  <= (!enable || tick) ? '0 : cnt + PW'(1);
      cs_q <= spi_cs;
    end
`ifdef JSTK_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wd;
  logic          in_xfer;
  assign in_xfer = (state == REQ) || (state == XFER);
  assign timeout = in_xfer && (wd == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) wd <= '0;
    else     wd <= in_xfer ? wd + TW'(1) : '0;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      spi_trigger   <= 1'b0;
      spi_out_bytes <= '0;
      x             <= '0;
      y             <= '0;
      buttons       <= '0;
      valid         <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout) begin
        state       <= IDLE;
        spi_trigger <= 1'b0;
        busy        <= 1'b0;
        err         <= 1'b1;
      end else
        case (state)
          IDLE: if (launch) begin
            state         <= REQ;
            spi_trigger   <= 1'b1;
            busy          <= 1'b1;
            spi_out_bytes <= {6'b100000, leds, 32'h0};
          end
          REQ: if (!cs_q) begin
            state       <= XFER;
            spi_trigger <= 1'b0;
          end
          XFER: if (cs_q) state <= LATCH;
          LATCH: begin
            x       <= {spi_in_bytes[25:24], spi_in_bytes[39:32]};
            y       <= {spi_in_bytes[9:8], spi_in_bytes[23:16]};
            buttons <= spi_in_bytes[2:0];
            valid   <= 1'b1;
            err     <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        endcase
    end
endmodule

// File: doc/jstk_poll_ctrl.md
# jstk_poll_ctrl

Transaction controller for the PmodJSTK joystick on the 50 MHz `clk` domain. It sits between the game logic and the 40-bit SPI master. It periodically or on demand launches one 5-byte transfer carrying the LED command, and tracks completion through the master's chip-select. It then unpacks the returned bytes into X/Y position and button state, with a one-cycle valid strobe.

## Interface
- `POLL_PERIOD`, 2_500_000: clk cycles between automatic transfer launches (20 Hz at 50 MHz); minimum 8192.
- `TIMEOUT_CYCLES`, 8192: clk-cycle limit for one transfer (REQ+XFER) before abort; only used with the watchdog.
- `clk` input 1: 50 MHz global clock.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: 1 = polling active; 0 = period counter held at 0 and `poll_now` ignored.
- `poll_now` input 1: one-cycle request for an immediate transfer.
- `leds` input 2: {LED2, LED1} to command on the next transfer.
- `spi_trigger` output 1: to SPI master `trigger`.
- `spi_out_bytes` output 40: to SPI master `out_bytes`.
- `spi_in_bytes` input 40: from SPI master `in_bytes`.
- `spi_cs` input 1: SPI master active-low chip-select, which is observed only.
- `x` output 10: joystick X, 0..1023.
- `y` output 10: joystick Y, 0..1023.
- `buttons` output 3: {trigger, btn2, btn1}.
- `valid` output 1: one-cycle pulse when `x`/`y`/`buttons` update.
- `busy` output 1: high in any state other than IDLE.
- `err` output 1: sticky timeout flag; cleared by the next successful LATCH or by reset.

## Operation
- `spi_cs` is registered once (`cs_q`) before any decision.
- **Period counter**
  - Counts 0..`POLL_PERIOD`-1 while `enable`=1 and wraps to 0.
  - Wrap produces `tick`.
- **Launch**
  - Launch condition is `enable` & (`tick` | `poll_now`) while in IDLE.
  - Launch requests outside IDLE are dropped, with no queueing.
- **FSM states**
  - IDLE: `spi_trigger`=0. On launch, load `spi_out_bytes` = {6'b100000, `leds`, 32'h0} and go to REQ.
  - REQ: `spi_trigger`=1. Go to XFER when `cs_q`=0.
  - XFER: `spi_trigger`=0. Go to LATCH when `cs_q`=1.
  - LATCH: capture fields from `spi_in_bytes`, pulse `valid`, clear `err`, then go to IDLE.
- **Field extraction**, byte0 = [39:32]:
  - `x` = {in[25:24], in[39:32]}
  - `y` = {in[9:8], in[23:16]}
  - `buttons` = in[2:0]
  - All other bits are ignored.
- `spi_out_bytes` holds its value from REQ entry through return to IDLE. It changes only on a launch.
- **Reset mid-transfer**: the FSM goes to IDLE and `spi_trigger` drops to 0. The SPI master completes its transfer on its own, and the result is discarded.

## Timing
- **Reset values**
  - `spi_trigger`=0, `spi_out_bytes`=40'h0
  - `x`=0, `y`=0, `buttons`=0
  - `valid`=0, `busy`=0, `err`=0
  - Period counter=0, state IDLE.
- Launch cycle N: `spi_trigger`=1 and `busy`=1 from cycle N+1.
- **REQ duration**: the SPI master samples `trigger` on its divided clock (period 64 clk), so REQ lasts between 2 and 66 clk cycles.
- **XFER duration**: about 40×64 clk cycles.
- `valid` is high exactly one cycle, the cycle after LATCH is entered. Outputs update in that same cycle and hold until the next LATCH.
- Back-to-back `poll_now` pulses: the first launches; the rest are dropped until IDLE.
- `tick` and `poll_now` in the same cycle produce exactly one launch.

## Configuration
- `JSTK_WATCHDOG_EN` defined:
  - A cycle counter runs in REQ and XFER.
  - When it reaches `TIMEOUT_CYCLES`-1: `spi_trigger`←0, `err`←1, state→IDLE, no `valid`.
- `JSTK_WATCHDOG_EN` undefined:
  - No timeout counter; REQ and XFER wait indefinitely.
  - `err` is tied to 0.

## Test plan
- **Reset mid-XFER**: `rst` pulsed during XFER → `spi_trigger`=0 and `busy`=0 asynchronously. The next launch succeeds normally.
- **Single poll**: `POLL_PERIOD`=10000, `enable`=1, `leds`=2'b10, SPI slave model returns 40'h2C_03_F1_01_05.
  - `spi_out_bytes`=40'h82_0000_0000.
  - Response: `x`=0x32C, `y`=0x1F1, `buttons`=3'b101, one `valid` pulse.
- **Periodic**: `POLL_PERIOD`=10000 for 50000 cycles → exactly 5 `valid` pulses, spaced 10000 cycles apart.
- **poll_now**:
  - Pulse while IDLE → transfer starts the next cycle.
  - Pulse while `busy` → no second transfer; `valid` count increases by 1.
- **Disabled**: `enable`=0 for 30000 cycles with `poll_now` pulses → `spi_trigger` never asserted; `valid` never asserted.
- **Watchdog**: with `JSTK_WATCHDOG_EN` and `spi_cs` stuck at 1:
  - After `TIMEOUT_CYCLES`: `err`=1, `busy`=0, no `valid`.
  - Then release `spi_cs` to the normal model → next successful transfer clears `err`.
